// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron sequencing control path.
package neuron_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StMac,
        StAct,
        StDone
    } seq_state_t;

    // Equals $clog2(n) for every legal n (n >= 2); never returns 0.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/weight_addr_counter.sv
// Weight/input select counter: steps 0..weight_n-1 while enabled, otherwise rests at 0.
module weight_addr_counter
    import neuron_pkg::*;
#(
    parameter int unsigned weight_n     = 5,
    parameter int unsigned addressWidth = addr_width(weight_n)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    output logic                    last,
    output logic [addressWidth-1:0] address
);

    localparam logic [addressWidth-1:0] LastAddr = addressWidth'(weight_n - 1);

    assign last = (address == LastAddr);

    // Returning to 0 after the last index keeps the count inside 0..weight_n-1.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            address <= '0;
        end else if (en) begin
            address <= last ? '0 : address + addressWidth'(1);
        end
    end

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Per-neuron sequencer: clear, multiply-accumulate over all weights, activate, signal done.
module neuron_seq_ctrl
    import neuron_pkg::*;
#(
    parameter int unsigned weight_n     = 5,
    parameter int unsigned data_width   = 16,
    localparam int unsigned addressWidth = addr_width(weight_n)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    done_in,
    output logic                    done_out,
    output logic [addressWidth-1:0] address,
    output logic                    acc_clr,
    output logic                    acc_en,
    output logic                    act_en,
    output logic                    freeze_r,
    output logic                    busy,
    output logic                    overrun
);

    if (weight_n < 2) begin : g_bad_weight_n
        $error("neuron_seq_ctrl: weight_n must be 2 or more");
    end
    if (data_width < 1) begin : g_bad_data_width
        $error("neuron_seq_ctrl: data_width must be 1 or more");
    end

    seq_state_t state_q, state_d;
    logic       pending_q, pending_d;
    logic       overrun_d;
    logic       last;

    weight_addr_counter #(
        .weight_n     (weight_n),
        .addressWidth (addressWidth)
    ) u_addr (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != StMac),
        .en      (state_q == StMac),
        .last    (last),
        .address (address)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = done_in ? StClear : StIdle;
            StClear: state_d = StMac;
            StMac:   state_d = last ? StAct : StMac;
            StAct:   state_d = StDone;
            StDone:  state_d = (pending_q || done_in) ? StClear : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A request in DONE restarts directly; one already pending there is consumed,
    // so a further request in that cycle is dropped.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun;
        if (state_q == StDone) begin
            pending_d = 1'b0;
            if (pending_q && done_in) overrun_d = 1'b1;
        end else if (state_q != StIdle && done_in) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            overrun   <= 1'b0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            act_en    <= 1'b0;
            done_out  <= 1'b0;
            freeze_r  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun   <= overrun_d;
            acc_clr   <= (state_d == StClear);
            acc_en    <= (state_d == StMac);
            act_en    <= (state_d == StAct);
            done_out  <= (state_d == StDone);
            freeze_r  <= (state_d != StMac);
            busy      <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Scoreboard bench for neuron_seq_ctrl: directed frames, back-to-back, overrun, reset, bounds.
module tb_neuron_seq_ctrl;

    localparam int W = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done_in = 1'b0;
    logic       done_out, acc_clr, acc_en, act_en, freeze_r, busy, overrun;
    logic [2:0] address;

    logic       lat_go = 1'b0;
    logic       d2_done, d2_clr, d2_en, d2_act, d2_frz, d2_busy, d2_ovr;
    logic [0:0] d2_addr;
    logic       d8_done, d8_clr, d8_en, d8_act, d8_frz, d8_busy, d8_ovr;
    logic [2:0] d8_addr;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int       cyc;
        logic [3:0] vec;   // {done_out, act_en, acc_en, acc_clr}
        int       addr;
        logic     frz;
    } ev_t;
    ev_t sb[$];

    neuron_seq_ctrl #(.weight_n(W), .data_width(16)) dut (
        .clk(clk), .rst(rst), .done_in(done_in), .done_out(done_out), .address(address),
        .acc_clr(acc_clr), .acc_en(acc_en), .act_en(act_en), .freeze_r(freeze_r),
        .busy(busy), .overrun(overrun)
    );

    neuron_seq_ctrl #(.weight_n(2), .data_width(8)) dut2 (
        .clk(clk), .rst(rst), .done_in(lat_go), .done_out(d2_done), .address(d2_addr),
        .acc_clr(d2_clr), .acc_en(d2_en), .act_en(d2_act), .freeze_r(d2_frz),
        .busy(d2_busy), .overrun(d2_ovr)
    );

    neuron_seq_ctrl #(.weight_n(8), .data_width(8)) dut8 (
        .clk(clk), .rst(rst), .done_in(lat_go), .done_out(d8_done), .address(d8_addr),
        .acc_clr(d8_clr), .acc_en(d8_en), .act_en(d8_act), .freeze_r(d8_frz),
        .busy(d8_busy), .overrun(d8_ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input logic [3:0] v, input int a, input logic f);
        ev_t e;
        e.cyc = c; e.vec = v; e.addr = a; e.frz = f;
        sb.push_back(e);
    endfunction

    // Frame whose done_in is sampled at the end of cycle t.
    function automatic void push_frame(input int t);
        push(t + 1, 4'b0001, 0, 1'b1);
        for (int i = 0; i < W; i++) push(t + 2 + i, 4'b0010, i, 1'b0);
        push(t + 2 + W, 4'b0100, 0, 1'b1);
        push(t + 3 + W, 4'b1000, 0, 1'b1);
    endfunction

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_at(input int n);
        goto(n);
        done_in = 1'b1;
        goto(n + 1);
        done_in = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        goto(cyc + 2);
        rst = 1'b0;
    endtask

    // Monitor: every active strobe cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [3:0] obs;
        ev_t e;
        obs = {done_out, act_en, acc_en, acc_clr};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event: cycle %0d got nothing, expected strobes %b", e.cyc, e.vec);
        end
        if (obs != 4'b0 || (sb.size() > 0 && sb[0].cyc == cyc)) begin
            checks++;
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_strobe at cycle %0d: got %b, expected 0000", cyc, obs);
            end else begin
                e = sb.pop_front();
                if (obs != e.vec || int'(address) != e.addr || freeze_r != e.frz) begin
                    errors++;
                    $display("FAIL strobe_cycle at cycle %0d: got %b addr=%0d frz=%b, expected %b addr=%0d frz=%b",
                             cyc, obs, address, freeze_r, e.vec, e.addr, e.frz);
                end
            end
        end
    end

    // Address range bound on the alternate widths.
    always @(negedge clk) begin
        if (int'(d2_addr) > 1 || int'(d8_addr) > 7) begin
            checks++;
            errors++;
            $display("FAIL addr_bound at cycle %0d: got %0d/%0d, expected <2/<8",
                     cyc, d2_addr, d8_addr);
        end
    end

    initial begin
        int b;
        int t2, t8;
        goto(2);
        // Reset values while rst is held
        chk("rst_busy", busy, 0);
        chk("rst_freeze", freeze_r, 1);
        chk("rst_addr", address, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_strobes", {done_out, act_en, acc_en, acc_clr}, 0);
        rst = 1'b0;

        // Single frame
        b = cyc + 1;
        push_frame(b);
        pulse_at(b);
        chk("single_busy_c1", busy, 1);
        goto(b + 9);
        chk("single_busy_c9", busy, 0);
        chk("single_addr_idle", address, 0);
        chk("single_overrun", overrun, 0);

        // Back-to-back: second request during MAC
        do_reset();
        b = cyc + 1;
        push_frame(b);
        push_frame(b + 8);
        pulse_at(b);
        pulse_at(b + 4);
        goto(b + 9);
        chk("b2b_busy_c9", busy, 1);
        goto(b + 17);
        chk("b2b_overrun", overrun, 0);
        chk("b2b_busy_end", busy, 0);

        // Overrun: third request while one is pending
        do_reset();
        b = cyc + 1;
        push_frame(b);
        push_frame(b + 8);
        pulse_at(b);
        pulse_at(b + 3);
        pulse_at(b + 5);
        chk("ovr_c6", overrun, 1);
        goto(b + 18);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_busy_end", busy, 0);

        // done_in held high for three cycles from idle
        do_reset();
        b = cyc + 1;
        push_frame(b);
        push_frame(b + 8);
        goto(b);
        done_in = 1'b1;
        goto(b + 2);
        chk("hold_ovr_c2", overrun, 0);
        goto(b + 3);
        done_in = 1'b0;
        chk("hold_ovr_c3", overrun, 1);
        goto(b + 18);
        chk("hold_busy_end", busy, 0);

        // Reset mid-MAC (overrun still set from above), done_in during rst ignored
        b = cyc + 1;
        push(b + 1, 4'b0001, 0, 1'b1);
        for (int i = 0; i < 3; i++) push(b + 2 + i, 4'b0010, i, 1'b0);
        pulse_at(b);
        goto(b + 4);
        rst = 1'b1;
        done_in = 1'b1;
        goto(b + 5);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", address, 0);
        chk("midrst_freeze", freeze_r, 1);
        chk("midrst_overrun", overrun, 0);
        push_frame(b + 5);
        goto(b + 6);
        done_in = 1'b0;
        chk("postrst_busy", busy, 1);
        goto(b + 15);
        chk("postrst_busy_end", busy, 0);

        // Latency for weight_n = 2 and 8
        b = cyc + 1;
        t2 = -1;
        t8 = -1;
        goto(b);
        lat_go = 1'b1;
        goto(b + 1);
        lat_go = 1'b0;
        for (int k = b + 1; k <= b + 16; k++) begin
            goto(k);
            if (d2_done && t2 < 0) t2 = k - b;
            if (d8_done && t8 < 0) t8 = k - b;
        end
        chk("latency_w2", t2, 5);
        chk("latency_w8", t8, 11);

        goto(cyc + 2);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
